// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one Clause-22 MDIO frame generator between NUM_REQ requesters.
// Latches the winner's frame, launches the generator, and returns read data, completion or timeout.
module mdio_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_REQ-1:0]      REQ,
    input  logic [NUM_REQ-1:0]      REQ_WR,
    input  logic [10*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [16*NUM_REQ-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]      GNT,
    output logic [NUM_REQ-1:0]      DONE_OUT,
    output logic [15:0]             RDATA,
    output logic                    ERR,
    output logic                    MDIO_START,
    output logic [31:0]             T_DATA,
    input  logic                    GEN_DONE,
    input  logic [15:0]             RD_DATA_IN
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        ptr, ptr_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
    logic [NUM_REQ-1:0]   done_q, done_nxt;
    logic [15:0]          rdata_q, rdata_nxt;
    logic                 err_q, err_nxt;
    logic                 start_q, start_nxt;
    logic [31:0]          tdata_q, tdata_nxt;
    logic                 cur_wr, cur_wr_nxt;

    logic [9:0]           addr_a  [NUM_REQ];
    logic [15:0]          wdata_a [NUM_REQ];
    logic                 win_found;
    logic [PW-1:0]        win_idx;
    int unsigned          cand;
    logic [31:0]          frame_c;

    // Unpack the flat per-requester buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = REQ_ADDR[i*10 +: 10];
            wdata_a[i] = REQ_WDATA[i*16 +: 16];
        end
    end

    // First pending request after the last winner, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!win_found && REQ[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign frame_c = {2'b01,
                      REQ_WR[win_idx] ? 2'b01 : 2'b10,
                      addr_a[win_idx][9:5],
                      addr_a[win_idx][4:0],
                      2'b10,
                      REQ_WR[win_idx] ? wdata_a[win_idx] : 16'h0000};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            ptr     <= PW'(NUM_REQ - 1);
            timer   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            tdata_q <= '0;
            cur_wr  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            timer   <= timer_nxt;
            gnt_q   <= gnt_nxt;
            done_q  <= done_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            start_q <= start_nxt;
            tdata_q <= tdata_nxt;
            cur_wr  <= cur_wr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        timer_nxt  = timer;
        gnt_nxt    = gnt_q;
        done_nxt   = '0;
        rdata_nxt  = rdata_q;
        err_nxt    = err_q;
        start_nxt  = 1'b0;
        tdata_nxt  = tdata_q;
        cur_wr_nxt = cur_wr;

        case (state)
            S_IDLE: begin
                gnt_nxt = '0;
                if (win_found) begin
                    gnt_nxt[win_idx] = 1'b1;
                    tdata_nxt        = frame_c;
                    cur_wr_nxt       = REQ_WR[win_idx];
                    ptr_nxt          = win_idx;
                    start_nxt        = 1'b1;
                    state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_nxt = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                timer_nxt = timer + TW'(1);
                // A completion in the timeout cycle still counts as success
                if (GEN_DONE) begin
                    rdata_nxt = cur_wr ? 16'h0000 : RD_DATA_IN;
                    err_nxt   = 1'b0;
                    done_nxt  = gnt_q;
                    state_nxt = S_RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    rdata_nxt = 16'h0000;
                    err_nxt   = 1'b1;
                    done_nxt  = gnt_q;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                gnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign GNT        = gnt_q;
    assign DONE_OUT   = done_q;
    assign RDATA      = rdata_q;
    assign ERR        = err_q;
    assign MDIO_START = start_q;
    assign T_DATA     = tdata_q;

endmodule
